// File: rtl/sram_dp_be_pkg.sv
// Shared definitions for the dual-port byte-enable SRAM: collision modes,
// clear-FSM encoding, latency legality check and the byte-lane merge.
package sram_pkg;

   localparam int MODE_READ_FIRST  = 0;
   localparam int MODE_WRITE_FIRST = 1;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int MERGE_W = 256;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } clr_state_e;

   function automatic logic rd_lat_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0]   old_word,
      input logic [MERGE_W-1:0]   new_word,
      input logic [MERGE_W/8-1:0] en
   );
      logic [MERGE_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MERGE_W / 8; i++) begin
         if (en[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_dp_be_rd_pipe.sv
// Read-result pipeline: LAT stages of data/valid/err. Data of a stage only
// moves when its valid does, so the last stage holds the most recent result.
module sram_rd_pipe #(
   parameter int DATA = 32,
   parameter int LAT  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   input  logic            in_err,
   input  logic [DATA-1:0] in_data,
   output logic            out_valid,
   output logic            out_err,
   output logic [DATA-1:0] out_data
);

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_stage
         logic            v_in;
         logic            e_in;
         logic [DATA-1:0] d_in;
         logic            valid_reg;
         logic            err_reg;
         logic [DATA-1:0] data_reg;

         if (gi == 0) begin : g_first
            assign v_in = in_valid;
            assign e_in = in_err;
            assign d_in = in_data;
         end else begin : g_next
            assign v_in = g_stage[gi-1].valid_reg;
            assign e_in = g_stage[gi-1].err_reg;
            assign d_in = g_stage[gi-1].data_reg;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg <= 1'b0;
               err_reg   <= 1'b0;
               data_reg  <= '0;
            end else begin
               valid_reg <= v_in & ~flush;
               err_reg   <= e_in & ~flush;
               if (v_in) data_reg <= d_in;
            end
         end
      end
   endgenerate

   assign out_valid = g_stage[LAT-1].valid_reg;
   assign out_err   = g_stage[LAT-1].err_reg;
   assign out_data  = g_stage[LAT-1].data_reg;

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte enables, RD_LAT-deep registered read,
// selectable collision behaviour, range checking and a post-reset clear walk.
module sram_dp_be
   import sram_pkg::*;
#(
   parameter int ADR    = 8,
   parameter int DATA   = 32,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1,
   parameter int MODE   = MODE_READ_FIRST
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   input  logic              cs,
   input  logic              we,
   input  logic [ADR-1:0]    wr_addr,
   input  logic [DATA-1:0]   data_in,
   input  logic [DATA/8-1:0] byte_en,
   input  logic              rd,
   input  logic [ADR-1:0]    rd_addr,
   output logic [DATA-1:0]   data_out,
   output logic              rd_valid,
   output logic              err
);

   localparam int NB = DATA / 8;

   generate
      if (!rd_lat_ok(RD_LAT) || (DATA % 8 != 0) || (DATA > MERGE_W) || (DEPTH > 2**ADR))
      begin : g_bad_param
         $error("sram_dp_be: illegal parameter combination");
      end
   endgenerate

   clr_state_e      state_reg, state_next;
   logic [ADR-1:0]  clr_cnt_reg, clr_cnt_next;
   logic            clr_we;

   logic [DATA-1:0] mem [DEPTH];

   logic            wr_acc, rd_acc, wr_oor, rd_oor, collide;
   logic [NB-1:0]   lane_we;
   logic [ADR-1:0]  mem_waddr;
   logic [DATA-1:0] mem_wdata, rd_word, rd_merged, rd_result;
   logic [MERGE_W-1:0] merge_wide;
   logic            wr_err_reg;
   logic            pipe_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      clr_we       = 1'b0;
      if (state_reg == CLEAR) begin
         clr_we       = 1'b1;
         clr_cnt_next = clr_cnt_reg + 1'b1;
         if (clr_cnt_reg == ADR'(DEPTH - 1)) state_next = RUN;
      end
   end

   assign ready  = (state_reg == RUN);
   assign wr_acc = cs & we & ready;
   assign rd_acc = cs & rd & ready;
   assign wr_oor = 32'(wr_addr) >= DEPTH;
   assign rd_oor = 32'(rd_addr) >= DEPTH;

   // The clear walk shares the write port; it writes every lane with zero.
   assign mem_waddr = clr_we ? clr_cnt_reg : wr_addr;
   assign mem_wdata = clr_we ? '0 : data_in;
   assign lane_we   = clr_we ? '1 : ((wr_acc & ~wr_oor) ? byte_en : '0);

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (lane_we[i]) mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   assign rd_word    = rd_oor ? '0 : mem[rd_addr];
   assign merge_wide = byte_merge(MERGE_W'(rd_word), MERGE_W'(data_in), (MERGE_W/8)'(byte_en));
   assign rd_merged  = merge_wide[DATA-1:0];

   generate
      if (DATA < MERGE_W) begin : g_sink
         logic unused_merge_hi;
         assign unused_merge_hi = ^merge_wide[MERGE_W-1:DATA];
      end
   endgenerate

   // Write-first bypass: the read sees the word as it will be after this edge.
   assign collide   = (MODE == MODE_WRITE_FIRST) && wr_acc && rd_acc && !wr_oor
                      && (wr_addr == rd_addr);
   assign rd_result = collide ? rd_merged : rd_word;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_err_reg <= 1'b0;
      else     wr_err_reg <= wr_acc & wr_oor;
   end

   sram_rd_pipe #(
      .DATA (DATA),
      .LAT  (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (~ready),
      .in_valid  (rd_acc),
      .in_err    (rd_acc & rd_oor),
      .in_data   (rd_result),
      .out_valid (rd_valid),
      .out_err   (pipe_err),
      .out_data  (data_out)
   );

   assign err = wr_err_reg | pipe_err;

endmodule

// File: tb/tb_sram_dp_be.sv
// Two SRAM instances (256/lat1/read-first and 200/lat2/write-first) share one
// stimulus stream and are checked every cycle against a word-level model.
module tb_sram_dp_be;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cs, we, rd;
   logic [7:0]  wr_addr, rd_addr;
   logic [31:0] data_in;
   logic [3:0]  byte_en;
   logic [1:0]  ready_o, valid_o, err_o;
   logic [31:0] dout [2];

   int tests = 0;
   int fails = 0;
   int rise0, rise1, stray;

   always #5 clk = ~clk;

   sram_dp_be #(.ADR(8), .DATA(32), .DEPTH(256), .RD_LAT(1), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .ready(ready_o[0]), .cs(cs), .we(we), .wr_addr(wr_addr),
      .data_in(data_in), .byte_en(byte_en), .rd(rd), .rd_addr(rd_addr),
      .data_out(dout[0]), .rd_valid(valid_o[0]), .err(err_o[0]));

   sram_dp_be #(.ADR(8), .DATA(32), .DEPTH(200), .RD_LAT(2), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .ready(ready_o[1]), .cs(cs), .we(we), .wr_addr(wr_addr),
      .data_in(data_in), .byte_en(byte_en), .rd(rd), .rd_addr(rd_addr),
      .data_out(dout[1]), .rd_valid(valid_o[1]), .err(err_o[1]));

   // ---------------- behavioural model ----------------
   typedef struct {
      int          k;
      longint      due;
      logic [31:0] d;
      bit          v;
      bit          er;
   } ev_t;

   int          dep [2] = '{256, 200};
   int          lat [2] = '{1, 2};
   int          mode[2] = '{0, 1};
   logic [31:0] mm  [2][256];
   int          cnt [2] = '{0, 0};
   bit          rdy_m[2] = '{0, 0};
   bit          exp_v[2] = '{0, 0};
   bit          exp_e[2] = '{0, 0};
   logic [31:0] exp_d[2] = '{32'h0, 32'h0};
   longint      e = 0;
   ev_t         evq[$];

   function automatic logic [31:0] lane_merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            evq.delete();
            for (int k = 0; k < 2; k++) begin
               cnt[k] = 0; rdy_m[k] = 0; exp_v[k] = 0; exp_e[k] = 0; exp_d[k] = 32'h0;
               for (int a = 0; a < 256; a++) mm[k][a] = 32'h0;
            end
         end else begin
            ev_t ev;
            ev_t keep[$];
            e++;
            for (int k = 0; k < 2; k++) begin
               if (rdy_m[k] && cs && rd) begin
                  ev.k = k; ev.due = e + lat[k] - 1; ev.v = 1;
                  if (rd_addr >= dep[k]) begin
                     ev.d = 32'h0; ev.er = 1;
                  end else begin
                     ev.d = mm[k][rd_addr]; ev.er = 0;
                     if (mode[k] == 1 && we && wr_addr == rd_addr)
                        ev.d = lane_merge(ev.d, data_in, byte_en);
                  end
                  evq.push_back(ev);
               end
               if (rdy_m[k] && cs && we) begin
                  if (wr_addr >= dep[k]) begin
                     ev.k = k; ev.due = e; ev.v = 0; ev.er = 1; ev.d = 32'h0;
                     evq.push_back(ev);
                  end else begin
                     mm[k][wr_addr] = lane_merge(mm[k][wr_addr], data_in, byte_en);
                  end
               end
               if (cnt[k] < dep[k]) cnt[k]++;
               rdy_m[k] = (cnt[k] >= dep[k]);
               exp_v[k] = 0;
               exp_e[k] = 0;
            end
            foreach (evq[i]) begin
               if (evq[i].due == e) begin
                  if (evq[i].v) begin
                     exp_v[evq[i].k] = 1;
                     exp_d[evq[i].k] = evq[i].d;
                  end
                  if (evq[i].er) exp_e[evq[i].k] = 1;
               end
               if (evq[i].due > e) keep.push_back(evq[i]);
            end
            evq = keep;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            tests++;
            if (ready_o[k] !== rdy_m[k] || valid_o[k] !== exp_v[k] ||
                err_o[k] !== exp_e[k] || dout[k] !== exp_d[k]) begin
               fails++;
               $display("FAIL cycle_check dut%0d t=%0t act rdy=%b vld=%b err=%b data=%h, required rdy=%b vld=%b err=%b data=%h",
                        k, $time, ready_o[k], valid_o[k], err_o[k], dout[k],
                        rdy_m[k], exp_v[k], exp_e[k], exp_d[k]);
            end
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end else begin
         $display("[TB] %s ok %h", nm, act);
      end
   endtask

   task automatic idle();
      cs = 0; we = 0; rd = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
      cs = 1; we = 1; rd = 0; wr_addr = a; data_in = d; byte_en = b;
      @(negedge clk); #1;
      idle();
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] a,
                         input logic [31:0] req0, input logic [31:0] req1);
      cs = 1; we = 0; rd = 1; rd_addr = a;
      @(negedge clk);
      chk({nm, "_d0"}, dout[0], req0);
      chk({nm, "_v0"}, 32'(valid_o[0]), 32'd1);
      chk({nm, "_model0"}, exp_d[0], req0);
      #1 idle();
      @(negedge clk);
      chk({nm, "_d1"}, dout[1], req1);
      chk({nm, "_v1"}, 32'(valid_o[1]), 32'd1);
      chk({nm, "_model1"}, exp_d[1], req1);
      #1;
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 3))
         0:       return 8'($urandom_range(0, 7));
         1:       return 8'($urandom_range(198, 201));
         2:       return 8'($urandom_range(240, 255));
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic do_clear(input bit noisy);
      rise0 = 0; rise1 = 0; stray = 0;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (ready_o[0] && rise0 == 0) rise0 = n;
         if (ready_o[1] && rise1 == 0) rise1 = n;
         if ((valid_o | err_o) != 2'b00) stray++;
         if (rise0 != 0 && rise1 != 0) break;
         #1;
         if (noisy && n < 190) begin
            cs = 1; we = 1'($urandom); rd = 1'($urandom);
            wr_addr = pick(); rd_addr = pick();
            data_in = $urandom | 32'h1; byte_en = 4'hF;
         end else begin
            idle();
         end
      end
      #1 idle();
      chk("ready_rise_d0", 32'(rise0), 32'd256);
      chk("ready_rise_d1", 32'(rise1), 32'd200);
      chk("no_access_while_clear", 32'(stray), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle();
      wr_addr = 0; rd_addr = 0; data_in = 0; byte_en = 0;
      #1 rst = 1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_err",   32'(err_o), 32'd0);
      chk("rst_dout0", dout[0], 32'h0);
      #1 rst = 0;
      do_clear(1);

      rd_chk("clr_rd_00", 8'h00, 32'h0, 32'h0);
      rd_chk("clr_rd_7f", 8'h7F, 32'h0, 32'h0);
      rd_chk("clr_rd_ff", 8'hFF, 32'h0, 32'h0);

      wr(8'h10, 32'h11223344, 4'b1111);
      wr(8'h10, 32'hAABBCCDD, 4'b0101);
      rd_chk("byte_write", 8'h10, 32'h11BB33DD, 32'h11BB33DD);

      cs = 1; we = 1; rd = 1; wr_addr = 8'h20; rd_addr = 8'h20;
      data_in = 32'hDEADBEEF; byte_en = 4'hF;
      @(negedge clk);
      chk("coll_read_first", dout[0], 32'h0);
      #1 we = 0;
      @(negedge clk);
      chk("coll_next_d0", dout[0], 32'hDEADBEEF);
      chk("coll_write_first", dout[1], 32'hDEADBEEF);
      #1 idle();
      @(negedge clk);
      chk("coll_next_d1", dout[1], 32'hDEADBEEF);
      #1;

      for (int i = 1; i <= 4; i++) wr(8'(i * 16), 32'(i * 16), 4'hF);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            cs = 1; rd = 1; we = 0; rd_addr = 8'((i + 1) * 16);
         end else begin
            idle();
         end
         @(negedge clk);
         chk("pipe_v0", 32'(valid_o[0]), 32'(i < 4));
         if (i < 4) chk("pipe_d0", dout[0], 32'((i + 1) * 16));
         chk("pipe_v1", 32'(valid_o[1]), 32'(i >= 1 && i <= 4));
         if (i >= 1 && i <= 4) chk("pipe_d1", dout[1], 32'(i * 16));
         #1;
      end

      cs = 1; we = 1; rd = 0; wr_addr = 8'hF0; data_in = 32'h55; byte_en = 4'hF;
      @(negedge clk);
      chk("oor_wr_err_d1", 32'(err_o[1]), 32'd1);
      chk("inr_wr_err_d0", 32'(err_o[0]), 32'd0);
      #1 we = 0; rd = 1; rd_addr = 8'hF0;
      @(negedge clk);
      chk("inr_rd_d0", dout[0], 32'h55);
      chk("oor_err_pulse_d1", 32'(err_o[1]), 32'd0);
      #1 idle();
      @(negedge clk);
      chk("oor_rd_err_d1", 32'(err_o[1]), 32'd1);
      chk("oor_rd_v_d1", 32'(valid_o[1]), 32'd1);
      chk("oor_rd_d1", dout[1], 32'h0);
      #1;

      for (int i = 0; i < 1500; i++) begin
         cs = ($urandom_range(0, 7) != 0);
         we = 1'($urandom); rd = 1'($urandom);
         wr_addr = pick();
         rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : pick();
         data_in = $urandom; byte_en = 4'($urandom);
         @(negedge clk); #1;
      end
      idle();
      wr(8'h10, 32'hCAFEF00D, 4'hF);
      repeat (3) begin @(negedge clk); #1; end

      cs = 1; rd = 1; we = 0; rd_addr = 8'h10;
      @(posedge clk); #2;
      rst = 1;
      idle();
      @(negedge clk);
      chk("midrst_ready", 32'(ready_o), 32'd0);
      chk("midrst_valid", 32'(valid_o), 32'd0);
      repeat (2) @(negedge clk);
      chk("midrst_no_late_v1", 32'(valid_o[1]), 32'd0);
      #1 rst = 0;
      do_clear(0);
      rd_chk("post_rst_10", 8'h10, 32'h0, 32'h0);
      rd_chk("post_rst_40", 8'h40, 32'h0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
